// File: rtl/lsu_dispatch_ctrl_if.sv
// Memory-side handshake between the LSU dispatch controller (master) and the data memory (slave).
interface lsu_dispatch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_dispatch_ctrl.sv
// Shares one load/store unit between two issue slots, slot 1 served first.
// Optional ack timeout abort enabled by defining LSU_TIMEOUT_EN.
module lsu_dispatch_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req1,
  input  logic                req2,
  input  logic                we1,
  input  logic                we2,
  input  logic [2:0]          funct1,
  input  logic [2:0]          funct2,
  input  logic [XLEN-1:0]     addr1,
  input  logic [XLEN-1:0]     addr2,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [XLEN-1:0]     wdata2,
  input  logic [4:0]          rd1,
  input  logic [4:0]          rd2,
  input  logic                flush,
  lsu_dispatch_ctrl_if.master mem,
  output logic                lsu_work,
  output logic                lsu_done,
  output logic                res1_valid,
  output logic                res2_valid,
  output logic [4:0]          res1_rd,
  output logic [4:0]          res2_rd,
  output logic [XLEN-1:0]     res1_data,
  output logic [XLEN-1:0]     res2_data,
  output logic                misalign1,
  output logic                misalign2,
  output logic                lsu_err
);

  typedef enum logic [1:0] {IDLE, MEM1, MEM2, DONE} state_t;

  state_t          state;
  logic            v2;
  logic [1:0]      ewe, ok, mis;
  logic [2:0]      efn   [2];
  logic [XLEN-1:0] eaddr [2];
  logic [XLEN-1:0] ewd   [2];
  logic [4:0]      erd   [2];
  logic [XLEN-1:0] rdat  [2];

  logic            sel, in_mem, cur_mis, advance;
  logic [1:0]      sz, a;
  logic [XLEN-1:0] lane, ld_fmt;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err;
`endif

  assign sel     = (state == MEM2);
  assign in_mem  = (state == MEM1) || (state == MEM2);
  assign sz      = efn[sel][1:0];
  assign a       = eaddr[sel][1:0];
  assign cur_mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
  assign advance = cur_mis || mem.mem_ack;

  always_comb begin
    mem.mem_req   = in_mem && !cur_mis;
    mem.mem_we    = ewe[sel];
    mem.mem_addr  = {eaddr[sel][XLEN-1:2], 2'b00};
    mem.mem_be    = 4'b1111;
    mem.mem_wdata = ewd[sel];
    case (sz)
      2'b00: begin
        mem.mem_be    = 4'b0001 << a;
        mem.mem_wdata = {(XLEN/8){ewd[sel][7:0]}};
      end
      2'b01: begin
        mem.mem_be    = 4'b0011 << a;
        mem.mem_wdata = {(XLEN/16){ewd[sel][15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane   = mem.mem_rdata >> {a, 3'b000};
    ld_fmt = lane;
    case (sz)
      2'b00:   ld_fmt = {{(XLEN-8){~efn[sel][2] & lane[7]}}, lane[7:0]};
      2'b01:   ld_fmt = {{(XLEN-16){~efn[sel][2] & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      v2    <= 1'b0;
      ewe   <= '0;
      ok    <= '0;
      mis   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        efn[i]   <= '0;
        eaddr[i] <= '0;
        ewd[i]   <= '0;
        erd[i]   <= '0;
        rdat[i]  <= '0;
      end
`ifdef LSU_TIMEOUT_EN
      tcnt <= '0;
      err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if ((req1 || req2) && !flush) begin
            v2       <= req2;
            ewe      <= {we2, we1};
            efn[0]   <= funct1;
            efn[1]   <= funct2;
            eaddr[0] <= addr1;
            eaddr[1] <= addr2;
            ewd[0]   <= wdata1;
            ewd[1]   <= wdata2;
            erd[0]   <= rd1;
            erd[1]   <= rd2;
            ok       <= '0;
            mis      <= '0;
`ifdef LSU_TIMEOUT_EN
            err      <= 1'b0;
            tcnt     <= '0;
`endif
            state    <= req1 ? MEM1 : MEM2;
          end
        end
        MEM1, MEM2: begin
          // a flush only cancels slot 2 while slot 1 is still outstanding
          if ((state == MEM1) && flush) v2 <= 1'b0;
          if (cur_mis) begin
            mis[sel] <= 1'b1;
          end else if (mem.mem_ack) begin
            ok[sel]   <= !ewe[sel] && (erd[sel] != 5'd0);
            rdat[sel] <= ld_fmt;
          end
          if (advance) state <= ((state == MEM1) && v2 && !flush) ? MEM2 : DONE;
`ifdef LSU_TIMEOUT_EN
          if (advance) begin
            tcnt <= '0;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            tcnt  <= '0;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu_done   = (state == DONE);
  assign lsu_work   = (state != IDLE) || ((req1 || req2) && !flush);
  assign res1_valid = lsu_done && ok[0];
  assign res2_valid = lsu_done && ok[1];
  assign res1_rd    = erd[0];
  assign res2_rd    = erd[1];
  assign res1_data  = rdat[0];
  assign res2_data  = rdat[1];
  assign misalign1  = lsu_done && mis[0];
  assign misalign2  = lsu_done && mis[1];
`ifdef LSU_TIMEOUT_EN
  assign lsu_err    = lsu_done && err;
`else
  assign lsu_err    = 1'b0;
`endif

endmodule

// File: doc/lsu_dispatch_ctrl.md
Name: lsu_dispatch_ctrl

Overview:
- Sequences the single shared load/store unit between the two issue slots of the dual-issue pipeline.
- Captures up to two memory ops per issue group and serves slot 1 (older) before slot 2.
- Drives the external memory handshake and formats load data.
- Produces lsu_work/lsu_done, which the pipeline control uses to stall the execute buffer and transfer registers.

Parameters:
- XLEN, 32: data/address width.
- TIMEOUT, 16: max wait cycles for mem_ack (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req1, req2  in  1  slot 1/2 presents a memory op
- we1, we2  in  1  1 = store, 0 = load
- funct1, funct2  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- addr1, addr2  in  XLEN  effective address
- wdata1, wdata2  in  XLEN  store data
- rd1, rd2  in  5  load destination
- flush  in  1  accepted jump; kill unissued ops
- mem_req  out  1  request valid
- mem_we  out  1  write
- mem_addr  out  XLEN  word address (addr & ~3)
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  access complete this cycle
- mem_rdata  in  XLEN  read word, valid with mem_ack
- lsu_work  out  1  LSU occupied
- lsu_done  out  1  group complete (1-cycle pulse)
- res1_valid, res2_valid  out  1  load result valid (DONE cycle only)
- res1_rd, res2_rd  out  5
- res1_data, res2_data  out  XLEN  extended load data
- misalign1, misalign2  out  1  op rejected as misaligned (DONE cycle only)
- lsu_err  out  1  timeout abort (optional feature)

Behaviour:
- Reset: state IDLE; all registered outputs, entry valids and results are 0; mem_req drops immediately, including mid-transaction.
- FSM states: IDLE, MEM1, MEM2, DONE.
- IDLE:
  - If (req1|req2) & !flush: latch both slot fields and entry valids.
  - Next state: MEM1 if entry1 is valid, else MEM2.
  - If flush: no capture.
- lsu_work = (state != IDLE) | ((req1|req2) & !flush & state == IDLE). lsu_work is combinational so the stall applies in the capture cycle.
- MEMx:
  - mem_req = 1, with mem_we/addr/be/wdata from entry x held stable until mem_ack.
  - On mem_ack: MEM1 -> MEM2 if entry2 valid, else DONE; MEM2 -> DONE.
  - Load data is registered on ack.
  - Ack in the first MEMx cycle is legal (single-cycle access).
- Misalignment: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - The entry skips the memory access (no mem_req) and sets misalignx.
  - It consumes one cycle in its MEM state.
- Byte enables: byte 4'b0001 << addr[1:0]; halfword 4'b0011 << addr[1:0]; word 4'b1111.
- Store data replication: byte replicated x4; halfword x2.
- Load extraction: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- DONE:
  - lsu_done = 1 and lsu_work = 1 for exactly one cycle.
  - resx_valid = entry valid & load & !misaligned & !cancelled.
  - Next state: IDLE.
  - req inputs in the DONE cycle are the completed group and are ignored.
- Latency, measured from the capture cycle C: one op with immediate ack gives lsu_done at C+2; two ops at C+3; each wait cycle adds 1.
- flush in MEM1:
  - The in-flight entry1 access completes and reports normally.
  - entry2 is cancelled: never issued, res2_valid = 0.
- flush in MEM2: the in-flight access completes and reports normally.
- flush in DONE: no effect.
- rd = x0 load: the access is performed, resx_valid = 0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter increments each MEMx cycle with mem_req = 1 and !mem_ack, and clears on state change.
  - When it reaches TIMEOUT, mem_req drops, the remaining entries are cancelled, and the FSM goes to DONE.
  - lsu_err pulses with lsu_done.
- Undefined: no counter; MEMx waits indefinitely; lsu_err is tied to 0.

Test Plan:
- req1 load LW addr 0x100, ack next cycle with rdata 0xDEADBEEF -> mem_be = 4'hF; lsu_done at C+2; res1_valid = 1, res1_data = 0xDEADBEEF.
- req1 SB addr 0x203, wdata 0xA5; req2 LH addr 0x202, rdata 0x80120000 -> first access be = 4'b1000, wdata = 0xA5A5A5A5; second access be = 4'b1100; res2_data = 0xFFFF8012; lsu_done at C+3.
- req1 LW addr 0x102 -> no mem_req, misalign1 = 1, res1_valid = 0, lsu_done at C+2.
- req1 and req2 loads; flush in MEM1 while ack is held off 2 cycles -> only one mem_req transaction; res1 valid, res2_valid = 0.
- Assert rst_n = 0 during MEM2 with mem_req = 1 -> mem_req = 0 and lsu_work = 0 immediately; IDLE after release.
- LSU_TIMEOUT_EN, TIMEOUT = 4, never ack -> mem_req drops after 4 cycles; lsu_done and lsu_err pulse together.
